pkt_rr_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter sharing one user-datapath output stream
//  (data/ctrl/wr/rdy) between NUM_QUEUES input streams. Each input is buffered in
//  its own FIFO. A grant is held until the granted packet's last word is forwarded.

---
 rtl/pkt_rr_arbiter.sv | 227 ++++++++++++++++++++++
 tb/tb_pkt_rr_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : pkt_rr_arbiter (with helper pkt_rr_fifo)
// Brief   : Packet-granular round-robin arbiter. Each input stream is
//           buffered in its own first-word-fall-through FIFO. One queue is
//           granted at a time, and the grant is held until that packet's last
//           word has been forwarded on the shared registered output stream.
// Revision: 1.0 - initial release
// ============================================================================

// ----------------------------------------------------------------------------
// Per-queue first-word-fall-through FIFO. A write is accepted while below
// the nearly-full level, or at that level when the same cycle also pops.
// This keeps occupancy constant at the limit and can never overflow.
// ----------------------------------------------------------------------------
module pkt_rr_fifo #(
  parameter int WIDTH      = 72,
  parameter int DEPTH_BITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_word,
  input  logic             rd,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             nearly_full
);

  localparam int                  DEPTH    = 1 << DEPTH_BITS;
  localparam logic [DEPTH_BITS:0] NF_LEVEL = (DEPTH_BITS + 1)'(DEPTH - 1);
  localparam logic [DEPTH_BITS:0] CNT_ONE  = (DEPTH_BITS + 1)'(1);
  localparam logic [DEPTH_BITS-1:0] PTR_ONE = DEPTH_BITS'(1);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count;
  logic                  pop;
  logic                  push;

  // A pop is only meaningful on a non-empty FIFO.
  assign pop         = rd && !empty;
  // Writes above the nearly-full level are dropped unless a pop frees a slot.
  assign push        = wr && (!nearly_full || pop);
  assign empty       = (count == '0);
  assign nearly_full = (count >= NF_LEVEL);
  // Head word is visible without a pop.
  assign head        = mem[rd_ptr];

  // Storage write port; left without reset so it can map onto RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_word;
    end
  end

  // Read/write pointers and occupancy counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (push && !pop) begin
        count <= count + CNT_ONE;
      end else if (pop && !push) begin
        count <= count - CNT_ONE;
      end
    end
  end

endmodule

// ----------------------------------------------------------------------------
// Top-level arbiter.
// ----------------------------------------------------------------------------
module pkt_rr_arbiter #(
  parameter  int DATA_WIDTH      = 64,
  parameter  int CTRL_WIDTH      = 8,
  parameter  int NUM_QUEUES      = 2,
  parameter  int FIFO_DEPTH_BITS = 5,
  localparam int QW              = (NUM_QUEUES > 1) ? $clog2(NUM_QUEUES) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_QUEUES*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_QUEUES*CTRL_WIDTH-1:0] in_ctrl,
  input  logic [NUM_QUEUES-1:0]          in_wr,
  output logic [NUM_QUEUES-1:0]          in_rdy,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [CTRL_WIDTH-1:0]          out_ctrl,
  output logic                           out_wr,
  input  logic                           out_rdy,
  output logic                           pkt_done,
  output logic [QW-1:0]                  pkt_done_src
);

  localparam int WORD_WIDTH = DATA_WIDTH + CTRL_WIDTH;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } state_t;

  state_t              state;
  logic [QW-1:0]       grant;
  logic [QW-1:0]       last_grant;
  logic                seen_payload;

  logic [NUM_QUEUES-1:0] empty;
  logic [NUM_QUEUES-1:0] nearly_full;
  logic [NUM_QUEUES-1:0] pop;
  logic [DATA_WIDTH-1:0] head_data [NUM_QUEUES];
  logic [CTRL_WIDTH-1:0] head_ctrl [NUM_QUEUES];

  logic                  grant_pop;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CTRL_WIDTH-1:0] sel_ctrl;
  logic                  rr_found;
  logic [QW-1:0]         rr_sel;

  // Only the granted queue is ever popped, and only when downstream is ready.
  assign grant_pop = (state == IN_PKT) && !empty[grant] && out_rdy;
  assign sel_data  = head_data[grant];
  assign sel_ctrl  = head_ctrl[grant];

  genvar gi;
  generate
    for (gi = 0; gi < NUM_QUEUES; gi++) begin : g_fifo
      logic [WORD_WIDTH-1:0] head_word;

      pkt_rr_fifo #(
        .WIDTH      (WORD_WIDTH),
        .DEPTH_BITS (FIFO_DEPTH_BITS)
      ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .wr          (in_wr[gi]),
        .wr_word     ({in_ctrl[gi*CTRL_WIDTH +: CTRL_WIDTH],
                       in_data[gi*DATA_WIDTH +: DATA_WIDTH]}),
        .rd          (pop[gi]),
        .head        (head_word),
        .empty       (empty[gi]),
        .nearly_full (nearly_full[gi])
      );

      assign pop[gi]       = grant_pop && (grant == QW'(gi));
      assign head_data[gi] = head_word[DATA_WIDTH-1:0];
      assign head_ctrl[gi] = head_word[DATA_WIDTH +: CTRL_WIDTH];
      // Ready is forced low while reset is held so upstream stops at once.
      assign in_rdy[gi]    = !reset && !nearly_full[gi];
    end
  endgenerate

  // Round-robin search: first non-empty queue after the last one that
  // finished a packet, wrapping around.
  always_comb begin
    int            cand;
    logic [QW-1:0] cidx;
    rr_found = 1'b0;
    rr_sel   = '0;
    cand     = 0;
    cidx     = '0;
    for (int k = 1; k <= NUM_QUEUES; k++) begin
      cand = (int'(last_grant) + k) % NUM_QUEUES;
      cidx = QW'(cand);
      if (!rr_found && !empty[cidx]) begin
        rr_found = 1'b1;
        rr_sel   = cidx;
      end
    end
  end

  // Grant FSM with registered output stream and end-of-packet pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      grant        <= '0;
      last_grant   <= QW'(NUM_QUEUES - 1);
      seen_payload <= 1'b0;
      out_wr       <= 1'b0;
      out_data     <= '0;
      out_ctrl     <= '0;
      pkt_done     <= 1'b0;
      pkt_done_src <= '0;
    end else begin
      out_wr   <= 1'b0;
      pkt_done <= 1'b0;
      case (state)
        IDLE: begin
          // Arbitration cycle: no pop here, which gives the idle gap.
          if (rr_found) begin
            grant        <= rr_sel;
            seen_payload <= 1'b0;
            state        <= IN_PKT;
          end
        end
        IN_PKT: begin
          // An empty granted FIFO simply stalls; the grant is not released.
          if (grant_pop) begin
            out_wr   <= 1'b1;
            out_data <= sel_data;
            out_ctrl <= sel_ctrl;
            if (sel_ctrl == '0) begin
              seen_payload <= 1'b1;
            end else if (seen_payload) begin
              last_grant   <= grant;
              pkt_done     <= 1'b1;
              pkt_done_src <= grant;
              state        <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pkt_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_pkt_rr_arbiter
// Brief   : Self-checking bench for pkt_rr_arbiter; directed scenarios plus
//           random traffic compared against a packet-level reference model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pkt_rr_arbiter;

  localparam int DW    = 64;
  localparam int CW    = 8;
  localparam int NQ    = 2;
  localparam int FDB   = 5;
  localparam int DEPTH = 1 << FDB;
  localparam int QW    = 1;

  typedef logic [CW+DW-1:0] word_t;

  logic            clk     = 1'b0;
  logic            reset   = 1'b1;
  logic [NQ*DW-1:0] in_data = '0;
  logic [NQ*CW-1:0] in_ctrl = '0;
  logic [NQ-1:0]   in_wr   = '0;
  logic [NQ-1:0]   in_rdy;
  logic [DW-1:0]   out_data;
  logic [CW-1:0]   out_ctrl;
  logic            out_wr;
  logic            out_rdy = 1'b0;
  logic            pkt_done;
  logic [QW-1:0]   pkt_done_src;

  pkt_rr_arbiter #(
    .DATA_WIDTH      (DW),
    .CTRL_WIDTH      (CW),
    .NUM_QUEUES      (NQ),
    .FIFO_DEPTH_BITS (FDB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .in_wr        (in_wr),
    .in_rdy       (in_rdy),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_wr       (out_wr),
    .out_rdy      (out_rdy),
    .pkt_done     (pkt_done),
    .pkt_done_src (pkt_done_src)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: per-queue word lists, grant bookkeeping, expected outputs.
  word_t mq [NQ][$];
  bit    m_busy = 1'b0;
  int    m_cur  = 0;
  int    m_last = NQ - 1;
  bit    m_seen = 1'b0;
  bit    e_wr   = 1'b0;
  bit    e_done = 1'b0;
  int    e_src  = 0;
  logic [DW-1:0] e_data = '0;
  logic [CW-1:0] e_ctrl = '0;

  // Stimulus state.
  word_t pend  [NQ][$];
  bit    frc   [NQ];
  word_t frc_w [NQ];
  int    n_out = 0;
  int    n_added = 0;
  int    done_log [$];

  function automatic word_t mk(input logic [CW-1:0] c);
    return {c, $urandom, $urandom};
  endfunction

  function automatic void add_pkt(input int q, input int nhdr, input int npay);
    for (int i = 0; i < nhdr; i++) pend[q].push_back(mk(CW'($urandom_range(1, 255))));
    for (int i = 0; i < npay; i++) pend[q].push_back(mk('0));
    pend[q].push_back(mk(CW'($urandom_range(1, 255))));
    n_added += nhdr + npay + 1;
  endfunction

  function automatic int pend_left();
    int s = 0;
    for (int i = 0; i < NQ; i++) s += pend[i].size();
    return s;
  endfunction

  function automatic int model_left();
    int s = 0;
    for (int i = 0; i < NQ; i++) s += mq[i].size();
    return s;
  endfunction

  // One clock of the reference model, evaluated with the inputs at the edge.
  function automatic void model_step();
    int    sz [NQ];
    bit    popped [NQ];
    word_t w;
    int    idx;
    if (reset) begin
      for (int i = 0; i < NQ; i++) mq[i].delete();
      m_busy = 1'b0; m_cur = 0; m_last = NQ - 1; m_seen = 1'b0;
      e_wr = 1'b0; e_done = 1'b0; e_src = 0; e_data = '0; e_ctrl = '0;
      return;
    end
    for (int i = 0; i < NQ; i++) begin
      sz[i] = mq[i].size();
      popped[i] = 1'b0;
    end
    e_wr   = 1'b0;
    e_done = 1'b0;
    if (!m_busy) begin
      for (int k = 1; k <= NQ; k++) begin
        idx = (m_last + k) % NQ;
        if (!m_busy && sz[idx] > 0) begin
          m_busy = 1'b1; m_cur = idx; m_seen = 1'b0;
        end
      end
    end else if (sz[m_cur] > 0 && out_rdy) begin
      w = mq[m_cur].pop_front();
      popped[m_cur] = 1'b1;
      e_wr   = 1'b1;
      e_ctrl = w[DW +: CW];
      e_data = w[DW-1:0];
      if (e_ctrl == '0) m_seen = 1'b1;
      else if (m_seen) begin
        e_done = 1'b1; e_src = m_cur; m_last = m_cur; m_busy = 1'b0;
      end
    end
    for (int i = 0; i < NQ; i++)
      if (in_wr[i] && (sz[i] < DEPTH - 1 || popped[i]))
        mq[i].push_back({in_ctrl[i*CW +: CW], in_data[i*DW +: DW]});
  endfunction

  // Compare DUT outputs with model expectations, away from the clock edge.
  task automatic monitor();
    bit er;
    check_eq("out_wr",   64'(out_wr),   64'(e_wr));
    check_eq("pkt_done", 64'(pkt_done), 64'(e_done));
    check_eq("out_data", out_data,      e_data);
    check_eq("out_ctrl", 64'(out_ctrl), 64'(e_ctrl));
    if (e_done) check_eq("done_src", 64'(pkt_done_src), 64'(e_src));
    for (int i = 0; i < NQ; i++) begin
      er = !reset && (mq[i].size() < DEPTH - 1);
      check_eq("in_rdy", 64'(in_rdy[i]), 64'(er));
    end
    if (out_wr) n_out++;
    if (pkt_done) done_log.push_back(int'(pkt_done_src));
  endtask

  // Drive this cycle's inputs, step the model at the edge, check on negedge.
  task automatic cycle();
    for (int i = 0; i < NQ; i++) begin
      word_t w;
      w = '0;
      if (frc[i]) begin
        w = frc_w[i]; frc[i] = 1'b0; in_wr[i] = 1'b1;
      end else if (pend[i].size() > 0 && in_rdy[i]) begin
        w = pend[i].pop_front(); in_wr[i] = 1'b1;
      end else begin
        in_wr[i] = 1'b0;
      end
      in_data[i*DW +: DW] = w[DW-1:0];
      in_ctrl[i*CW +: CW] = w[DW +: CW];
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
    monitor();
  endtask

  task automatic drain(input int max);
    int n = 0;
    out_rdy = 1'b1;
    while ((pend_left() > 0 || model_left() > 0 || m_busy) && n < max) begin
      cycle();
      n++;
    end
    cycle();
    cycle();
    check_eq("drain_left", 64'(pend_left() + model_left()), 64'd0);
  endtask

  task automatic do_reset();
    #2 reset = 1'b1;
    for (int i = 0; i < NQ; i++) pend[i].delete();
    out_rdy = 1'b0;
    cycle();
    cycle();
    #1 reset = 1'b0;
  endtask

  function automatic int log_at(input int k);
    return (k < done_log.size()) ? done_log[k] : 99;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_n;
    int base_o;
    int n;
    for (int i = 0; i < NQ; i++) frc[i] = 1'b0;

    // Reset state
    cycle();
    cycle();
    check_eq("rst_in_rdy", 64'(in_rdy), 64'd0);
    check_eq("rst_out_wr", 64'(out_wr), 64'd0);
    #3 reset = 1'b0;
    #1 check_eq("rel_in_rdy", 64'(in_rdy), 64'(2'b11));

    // Single q0 packet FF,FF,00,00,00,04
    pend[0].push_back(mk(8'hFF));
    pend[0].push_back(mk(8'hFF));
    pend[0].push_back(mk(8'h00));
    pend[0].push_back(mk(8'h00));
    pend[0].push_back(mk(8'h00));
    pend[0].push_back(mk(8'h04));
    out_rdy = 1'b1;
    drain(100);
    check_eq("t1_words", 64'(n_out), 64'd6);
    check_eq("t1_src",   64'(log_at(0)), 64'd0);

    // Two packets per queue, interleaved q0,q1,q0,q1
    do_reset();
    base_n = done_log.size();
    add_pkt(0, 1, 3);
    add_pkt(0, 0, 2);
    add_pkt(1, 2, 2);
    add_pkt(1, 1, 1);
    n = 0;
    while (pend_left() > 0 && n < 100) begin cycle(); n++; end
    drain(200);
    for (int k = 0; k < 4; k++) check_eq("t2_order", 64'(log_at(base_n + k)), 64'(k % 2));

    // Downstream stall mid-packet
    base_o = n_out;
    add_pkt(0, 1, 10);
    out_rdy = 1'b1;
    repeat (8) cycle();
    out_rdy = 1'b0;
    repeat (5) cycle();
    drain(200);
    check_eq("t3_words", 64'(n_out - base_o), 64'd12);

    // q1 granted and starved while q0 fills
    base_o = n_out;
    base_n = done_log.size();
    pend[1].push_back(mk(8'h22));
    pend[1].push_back(mk(8'h00));
    pend[1].push_back(mk(8'h00));
    out_rdy = 1'b1;
    repeat (10) cycle();
    add_pkt(0, 1, 29);
    repeat (45) cycle();
    check_eq("t4_held", 64'(n_out - base_o), 64'd3);
    pend[1].push_back(mk(8'h00));
    pend[1].push_back(mk(8'h33));
    drain(300);
    check_eq("t4_first", 64'(log_at(base_n)), 64'd1);
    check_eq("t4_second", 64'(log_at(base_n + 1)), 64'd0);

    // Fill q0 to the nearly-full level, then push and pop together
    base_o = n_out;
    out_rdy = 1'b0;
    add_pkt(0, 1, 29);
    n = 0;
    while (pend[0].size() > 0 && n < 100) begin cycle(); n++; end
    cycle();
    check_eq("t5_nf", 64'(in_rdy[0]), 64'd0);
    frc[0]   = 1'b1;
    frc_w[0] = mk(8'h11);
    n_added++;
    out_rdy  = 1'b1;
    cycle();
    out_rdy  = 1'b0;
    cycle();
    check_eq("t5_nf_hold", 64'(in_rdy[0]), 64'd0);
    for (int i = 0; i < 3; i++) pend[0].push_back(mk('0));
    pend[0].push_back(mk(8'h44));
    drain(300);
    check_eq("t5_words", 64'(n_out - base_o), 64'd36);

    // Asynchronous reset mid-packet, then a q1-only packet
    add_pkt(0, 1, 8);
    out_rdy = 1'b0;
    n = 0;
    while (pend[0].size() > 0 && n < 100) begin cycle(); n++; end
    out_rdy = 1'b1;
    repeat (4) cycle();
    #3 check_eq("t6_pre_wr", 64'(out_wr), 64'd1);
    reset = 1'b1;
    #1;
    check_eq("t6_out_wr",   64'(out_wr),   64'd0);
    check_eq("t6_pkt_done", 64'(pkt_done), 64'd0);
    check_eq("t6_in_rdy",   64'(in_rdy),   64'd0);
    pend[0].delete();
    cycle();
    cycle();
    #3 reset = 1'b0;
    base_o = n_out;
    base_n = done_log.size();
    add_pkt(1, 1, 4);
    drain(200);
    check_eq("t6_words", 64'(n_out - base_o), 64'd6);
    check_eq("t6_src",   64'(log_at(base_n)), 64'd1);

    // Random traffic with random downstream back-pressure
    do_reset();
    base_o  = n_out;
    n_added = 0;
    for (int c = 0; c < 1500; c++) begin
      int q;
      out_rdy = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 5) == 0) begin
        q = $urandom_range(0, NQ - 1);
        if (pend[q].size() < 64) add_pkt(q, $urandom_range(0, 2), $urandom_range(1, 6));
      end
      cycle();
    end
    drain(3000);
    check_eq("rand_words", 64'(n_out - base_o), 64'(n_added));

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
